// File: rtl/dab_pkg.sv
// ============================================================================
// Module : dab_pkg
// Shared state encoding and width/range constants for the DAB setpoint
// sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dab_pkg;

  localparam int T_W     = 9;
  localparam int FS_W    = 19;
  localparam int T_MAX   = 255;
  localparam int PHI_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_RUN      = 2'd2,
    ST_RAMPDOWN = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dab_slew_step.sv
// ============================================================================
// Module : dab_slew_step
// Moves one signed setpoint toward its target by at most step_i per call.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dab_slew_step
  import dab_pkg::*;
(
  input  logic signed [T_W-1:0] cur_i,
  input  logic signed [T_W-1:0] tgt_i,
  input  logic        [T_W-1:0] step_i,
  output logic signed [T_W-1:0] nxt_o
);

  logic signed [T_W:0] diff;
  logic signed [T_W:0] stp;

  // The result always lies between cur_i and tgt_i, so the 9-bit
  // add/subtract below cannot wrap.
  always_comb begin
    diff  = {tgt_i[T_W-1], tgt_i} - {cur_i[T_W-1], cur_i};
    stp   = {1'b0, step_i};
    nxt_o = tgt_i;
    if (diff > stp) begin
      nxt_o = cur_i + step_i;
    end else if (diff < -stp) begin
      nxt_o = cur_i - step_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dab_setpoint_sequencer.sv
// ============================================================================
// Module : dab_setpoint_sequencer
// Range-checks host setpoints and applies them to the DAB modulator on
// switching-period boundaries; owns power-up/shutdown sequencing and sync.
// Option : DAB_SLEW_EN -- rate-limit t1/t2/phi per period (else jump).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dab_setpoint_sequencer
  import dab_pkg::*;
#(
  parameter int DIV_LAT    = 40,
  parameter int T_STEP     = 4,
  parameter int PHI_STEP   = 2,
  parameter int FS_MIN     = 1000,
  parameter int FS_MAX     = 150000,
  parameter int FS_DEFAULT = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic signed [T_W-1:0]  cmd_t1,
  input  logic signed [T_W-1:0]  cmd_t2,
  input  logic signed [T_W-1:0]  cmd_phi,
  input  logic signed [FS_W-1:0] cmd_fs,
  input  logic                   trigger,
  output logic signed [T_W-1:0]  t1,
  output logic signed [T_W-1:0]  t2,
  output logic signed [T_W-1:0]  phi,
  output logic signed [FS_W-1:0] fs_DAB,
  output logic                   sync,
  output logic                   running,
  output logic                   cmd_err
);

  localparam int CNT_W = $clog2(DIV_LAT + 2);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DIV_LAT + 1);

  localparam logic signed [T_W-1:0]  T_LO   = '0;
  localparam logic signed [T_W-1:0]  T_HI   = T_W'(T_MAX);
  localparam logic signed [T_W-1:0]  PHI_HI = T_W'(PHI_MAX);
  localparam logic signed [T_W-1:0]  PHI_LO = T_W'(-PHI_MAX);
  localparam logic signed [FS_W-1:0] FS_LO  = FS_W'(FS_MIN);
  localparam logic signed [FS_W-1:0] FS_HI  = FS_W'(FS_MAX);
  localparam logic signed [FS_W-1:0] FS_RST = FS_W'(FS_DEFAULT);

`ifdef DAB_SLEW_EN
  localparam logic [T_W-1:0] T_STP   = T_W'(T_STEP);
  localparam logic [T_W-1:0] PHI_STP = T_W'(PHI_STEP);
`else
  // Full-scale step: every output lands on its target in one period.
  localparam logic [T_W-1:0] T_STP   = T_W'(T_STEP) | {T_W{1'b1}};
  localparam logic [T_W-1:0] PHI_STP = T_W'(PHI_STEP) | {T_W{1'b1}};
`endif

  state_e                 state_q, state_d;
  logic                   trig_q, bnd_q;
  logic                   ready_q, err_q, sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic signed [T_W-1:0]  t1_q, t1_d, t2_q, t2_d, phi_q, phi_d;
  logic signed [FS_W-1:0] fs_q, fs_d;
  logic signed [T_W-1:0]  tgt_t1_q, tgt_t2_q, tgt_phi_q;
  logic signed [FS_W-1:0] tgt_fs_q;

  logic                   w_accept, w_legal, w_rampdown, w_zero;
  logic signed [T_W-1:0]  w_t1_tgt, w_t2_tgt, w_phi_tgt;
  logic signed [T_W-1:0]  w_t1_nxt, w_t2_nxt, w_phi_nxt;

  assign w_accept = cmd_valid & ready_q;
  assign w_legal  = (cmd_t1 >= T_LO) && (cmd_t1 <= T_HI) &&
                    (cmd_t2 >= T_LO) && (cmd_t2 <= T_HI) &&
                    (cmd_phi >= PHI_LO) && (cmd_phi <= PHI_HI) &&
                    (cmd_fs >= FS_LO) && (cmd_fs <= FS_HI);

  // Shutdown steps toward zero while the host targets stay stored.
  assign w_rampdown = (state_q == ST_RAMPDOWN);
  assign w_t1_tgt   = w_rampdown ? T_LO : tgt_t1_q;
  assign w_t2_tgt   = w_rampdown ? T_LO : tgt_t2_q;
  assign w_phi_tgt  = w_rampdown ? T_LO : tgt_phi_q;
  assign w_zero     = (t1_q == T_LO) && (t2_q == T_LO) && (phi_q == T_LO);

  dab_slew_step u_step_t1 (
    .cur_i  (t1_q),
    .tgt_i  (w_t1_tgt),
    .step_i (T_STP),
    .nxt_o  (w_t1_nxt)
  );

  dab_slew_step u_step_t2 (
    .cur_i  (t2_q),
    .tgt_i  (w_t2_tgt),
    .step_i (T_STP),
    .nxt_o  (w_t2_nxt)
  );

  dab_slew_step u_step_phi (
    .cur_i  (phi_q),
    .tgt_i  (w_phi_tgt),
    .step_i (PHI_STP),
    .nxt_o  (w_phi_nxt)
  );

  always_comb begin
    state_d = state_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    phi_d   = phi_q;
    fs_d    = fs_q;
    cnt_d   = cnt_q;
    sync_d  = sync_q;
    case (state_q)
      ST_IDLE: begin
        t1_d   = T_LO;
        t2_d   = T_LO;
        phi_d  = T_LO;
        sync_d = 1'b0;
        if (en) begin
          fs_d    = tgt_fs_q;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!en) begin
          state_d = ST_RAMPDOWN;
        end else if (cnt_q == CNT_TERM) begin
          state_d = ST_RUN;
          sync_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_d = ST_RAMPDOWN;
        end else if (bnd_q) begin
          if (tgt_fs_q != fs_q) begin
            fs_d    = tgt_fs_q;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end else begin
            t1_d  = w_t1_nxt;
            t2_d  = w_t2_nxt;
            phi_d = w_phi_nxt;
          end
        end
      end
      ST_RAMPDOWN: begin
        if (en) begin
          state_d = ST_RUN;
          sync_d  = 1'b1;
        end else if (w_zero) begin
          state_d = ST_IDLE;
          sync_d  = 1'b0;
        end else if (bnd_q) begin
          t1_d  = w_t1_nxt;
          t2_d  = w_t2_nxt;
          phi_d = w_phi_nxt;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      trig_q  <= 1'b0;
      bnd_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      sync_q  <= 1'b0;
      cnt_q   <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      phi_q   <= '0;
      fs_q    <= FS_RST;
    end else begin
      state_q <= state_d;
      trig_q  <= trigger;
      bnd_q   <= trigger & ~trig_q;
      ready_q <= (state_d == ST_IDLE) || (state_d == ST_RUN);
      err_q   <= w_accept & ~w_legal;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      phi_q   <= phi_d;
      fs_q    <= fs_d;
    end
  end

  // A command accepted on a boundary edge is seen by the following boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_t1_q  <= '0;
      tgt_t2_q  <= '0;
      tgt_phi_q <= '0;
      tgt_fs_q  <= FS_RST;
    end else if (w_accept && w_legal) begin
      tgt_t1_q  <= cmd_t1;
      tgt_t2_q  <= cmd_t2;
      tgt_phi_q <= cmd_phi;
      tgt_fs_q  <= cmd_fs;
    end
  end

  assign cmd_ready = ready_q;
  assign cmd_err   = err_q;
  assign sync      = sync_q;
  assign running   = (state_q == ST_RUN);
  assign t1        = t1_q;
  assign t2        = t2_q;
  assign phi       = phi_q;
  assign fs_DAB    = fs_q;

endmodule

`default_nettype wire

// File: doc/dab_setpoint_sequencer.md
Name: dab_setpoint_sequencer

Overview:
- Sequences the operating point of the DAB modulator (`voltajes`): pulse widths t1/t2, phase shift phi, switching frequency fs_DAB.
- Host commands arrive over a valid/ready port; the block range-checks them and holds them as targets.
- Targets are applied only at switching-period boundaries, taken from the modulator's trigger.
- Owns the modulator `sync` start signal. Runs the power-up sequence (settle divider, then sync) and the shutdown sequence (ramp to zero, then idle).

Parameters:
- DIV_LAT, 40: divider pipeline latency in clk cycles; used as the settle wait.
- T_STEP, 4: max change of t1/t2 per period (slew mode).
- PHI_STEP, 2: max change of phi per period (slew mode).
- FS_MIN, 1000: lowest legal fs_DAB in Hz.
- FS_MAX, 150000: highest legal fs_DAB in Hz.
- FS_DEFAULT, 50000: fs target after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  level; 1 = converter run request
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command ready
- cmd_t1  in  9 signed  requested t1, legal 0..255
- cmd_t2  in  9 signed  requested t2, legal 0..255
- cmd_phi  in  9 signed  requested phi, legal -255..255
- cmd_fs  in  19 signed  requested fs in Hz, legal FS_MIN..FS_MAX
- trigger  in  1  modulator trigger; its rising edge marks period start
- t1, t2, phi  out  9 signed  applied values to modulator
- fs_DAB  out  19 signed  applied frequency to modulator
- sync  out  1  modulator start level
- running  out  1  high in RUN
- cmd_err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - Outputs: t1=t2=phi=0, fs_DAB=FS_DEFAULT, sync=0, running=0, cmd_err=0, cmd_ready=0.
  - Targets: t=0, phi=0, fs=FS_DEFAULT.
  - Edge-detect register cleared.
- Boundary: bnd = trigger & ~trigger_q, registered, so it acts 1 cycle after the edge.
- Handshake:
  - cmd_ready=1 in IDLE and RUN; 0 in SETTLE and RAMPDOWN.
  - Accept on cmd_valid&cmd_ready. Legal commands update all four targets at that edge.
  - Any illegal field, including phi=-256: no target changes, cmd_err=1 the next cycle.
  - cmd_valid held while ready=0 waits; it is not dropped.
- State machine:
  - IDLE: outputs t/phi=0, sync=0.
    - On en=1: load fs_DAB <= fs target, clear settle counter, go to SETTLE.
  - SETTLE: counts DIV_LAT+2 cycles; outputs t/phi stay as they are.
    - At terminal count: go to RUN with sync=1 from the next cycle.
    - en=0 during SETTLE: go to RAMPDOWN.
  - RUN: sync=1, running=1.
    - On bnd: if the fs target differs from fs_DAB, load fs_DAB and go to SETTLE (sync stays 1, t/phi frozen). Otherwise step t1, t2, phi toward their targets.
    - en=0: go to RAMPDOWN.
  - RAMPDOWN: cmd_ready=0, sync=1. Effective targets are t=0, phi=0; stored targets are kept.
    - On bnd: step toward zero.
    - When t1=t2=phi=0: go to IDLE, sync=0. If no boundary arrives, it waits.
    - en=1 during RAMPDOWN: return to RUN at the same cycle's next edge, with targets unchanged.
- Step rule, slew mode: if |target-cur| <= STEP then cur=target, else cur += sign*STEP. Arithmetic in 10-bit signed; the result never leaves the legal range.
- Simultaneous command accept and bnd: the step uses the pre-accept target. The new target takes effect at the next bnd.
- Reset mid-operation: immediate return to reset values; the modulator stops at its next `sync`-less restart.

Optional Feature:
- Macro: DAB_SLEW_EN.
- Defined: step rule as above, using T_STEP/PHI_STEP.
- Undefined: on bnd, outputs jump straight to the target (zero in RAMPDOWN). RAMPDOWN then completes at the first boundary. T_STEP/PHI_STEP are unused.

Decomposition:
- Package dab_pkg holds:
  - state encoding (IDLE, SETTLE, RUN, RAMPDOWN);
  - width constants T_W=9, FS_W=19;
  - legal-range constants T_MAX=255, PHI_MAX=255.
- One sub-module, dab_slew_step: combinational step of one 9-bit signed value toward its target, with a step input. Instantiated three times.

Test Plan:
- Reset, then en=1 with no command → fs_DAB=50000, sync rises exactly DIV_LAT+3 cycles after en, t/phi=0.
- In RUN, command t1=20, t2=10, phi=-7 (slew) → t1 follows 4, 8, 12, 16, 20 on successive boundaries; t2 reaches 10 by the 3rd boundary; phi goes -2, -4, -6, -7.
- Command fs=200000, then t1=300, then phi=-256 → cmd_err pulses ×3, outputs and targets unchanged.
- Command fs=100000 in RUN → fs_DAB updates 1 cycle after the next bnd, then a DIV_LAT+2 freeze with no t/phi steps despite boundaries, then RUN resumes.
- en=0 with t1=8, phi=-3 → RAMPDOWN, cmd_ready=0; t1 goes 4 then 0; phi goes -1 then 0; then IDLE with sync=0. Repeat with DAB_SLEW_EN undefined → zero after 1 boundary.
- rst_n pulled low mid-RAMPDOWN and the command accept coinciding with bnd → async clear to reset values; the coincident step uses the old target.
